// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared pipeline codes and the M-stage register layout
package mem_stage_pkg;

    // Memory operation codes carried from E into M; 9-15 decode as no access
    localparam logic [3:0] MEMOP_NONE = 4'd0;
    localparam logic [3:0] MEMOP_LW   = 4'd1;
    localparam logic [3:0] MEMOP_LH   = 4'd2;
    localparam logic [3:0] MEMOP_LHU  = 4'd3;
    localparam logic [3:0] MEMOP_LB   = 4'd4;
    localparam logic [3:0] MEMOP_LBU  = 4'd5;
    localparam logic [3:0] MEMOP_SW   = 4'd6;
    localparam logic [3:0] MEMOP_SH   = 4'd7;
    localparam logic [3:0] MEMOP_SB   = 4'd8;

    // Register-file write-data source for the instruction held in M
    localparam logic [1:0] WDSEL_MEM = 2'b00;
    localparam logic [1:0] WDSEL_ALU = 2'b01;
    localparam logic [1:0] WDSEL_PC  = 2'b10;
    localparam logic [1:0] WDSEL_MD  = 2'b11;

    // Everything the M stage remembers about its instruction
    typedef struct packed {
        logic [31:0] result;
        logic [31:0] rt;
        logic [31:0] pcn;
        logic [31:0] op;
        logic [31:0] md;
        logic [4:0]  a3;
        logic        regwrite;
        logic [3:0]  mem_op;
    } m_stage_t;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory port between the M stage and the data RAM
interface mem_stage_if;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;

    modport master (
        output m_data_addr,
        output m_data_wdata,
        output m_data_byteen,
        input  m_data_rdata
    );

    modport slave (
        input  m_data_addr,
        input  m_data_wdata,
        input  m_data_byteen,
        output m_data_rdata
    );
endinterface

// File: rtl/mem_lane_unit.sv
// rtl/mem_lane_unit.sv - byte enables, store lane replication, load extension (MEM_ALIGN_CHECK_EN)
module mem_lane_unit
    import mem_stage_pkg::*;
(
    input  logic [3:0]  mem_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  byteen,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic        misaligned;

    // Pick the addressed lanes, then shape store data / enables and extend loads
    always_comb begin
        byteen     = 4'b0000;
        wdata      = store_data;
        load_data  = 32'd0;
        misaligned = 1'b0;

        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

`ifdef MEM_ALIGN_CHECK_EN
        case (mem_op)
            MEMOP_LW, MEMOP_SW:            misaligned = (addr_lo != 2'd0);
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: misaligned = addr_lo[0];
            default:                       misaligned = 1'b0;
        endcase
`endif

        case (mem_op)
            MEMOP_LW:  load_data = rdata;
            MEMOP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            MEMOP_LHU: load_data = {16'd0, half_sel};
            MEMOP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_LBU: load_data = {24'd0, byte_sel};
            MEMOP_SW:  byteen = 4'b1111;
            MEMOP_SH: begin
                byteen = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata  = {2{store_data[15:0]}};
            end
            MEMOP_SB: begin
                byteen = 4'b0001 << addr_lo;
                wdata  = {4{store_data[7:0]}};
            end
            default: ;
        endcase

        // A misaligned access neither writes nor returns data
        if (misaligned) begin
            byteen    = 4'b0000;
            load_data = 32'd0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline M stage: E/M register, data-memory access, forwarding (MEM_ALIGN_CHECK_EN)
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         result_E_o,
    input  logic [31:0]         rt_E_o,
    input  logic [31:0]         PCn_E_o,
    input  logic [31:0]         OP_E_o,
    input  logic [4:0]          A3_E_o,
    input  logic                regWrite_E_o,
    input  logic [31:0]         md_E_o,
    input  logic [3:0]          memOp_E_o,
    input  logic [1:0]          GRF_WDsel,
    input  logic [31:0]         W_forward,
    input  logic [4:0]          W_A3,
    input  logic                W_regWrite,
    mem_stage_if.master         dmem,
    output logic [31:0]         memory_M_o,
    output logic [31:0]         result_M_o,
    output logic [31:0]         md_M_o,
    output logic [31:0]         PCn_M_o,
    output logic [31:0]         OP_M_o,
    output logic [4:0]          A3_M_o,
    output logic                regWrite_M_o,
    output logic [31:0]         M_forward
);

    m_stage_t    stage_d;
    m_stage_t    stage_q;
    logic [31:0] store_data;

    // Next E/M register contents; reset clears the whole stage, cancelling any pending store
    always_comb begin
        stage_d = '0;
        if (!reset) begin
            stage_d.result   = result_E_o;
            stage_d.rt       = rt_E_o;
            stage_d.pcn      = PCn_E_o;
            stage_d.op       = OP_E_o;
            stage_d.md       = md_E_o;
            stage_d.a3       = A3_E_o;
            stage_d.regwrite = regWrite_E_o;
            stage_d.mem_op   = memOp_E_o;
        end
    end

    // E/M pipeline register
    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    // Store data bypass from W: lets a load immediately followed by a dependent store proceed without a stall
    always_comb begin
        store_data = stage_q.rt;
        if (W_regWrite && (W_A3 != 5'd0) && (W_A3 == stage_q.op[20:16])) begin
            store_data = W_forward;
        end
    end

    mem_lane_unit u_lane (
        .mem_op     (stage_q.mem_op),
        .addr_lo    (stage_q.result[1:0]),
        .store_data (store_data),
        .rdata      (dmem.m_data_rdata),
        .byteen     (dmem.m_data_byteen),
        .wdata      (dmem.m_data_wdata),
        .load_data  (memory_M_o)
    );

    // Value offered to earlier stages; load data is not yet known here, so it forwards 0
    always_comb begin
        M_forward = 32'd0;
        case (GRF_WDsel)
            WDSEL_ALU: M_forward = stage_q.result;
            WDSEL_PC:  M_forward = stage_q.pcn + 32'd4;
            WDSEL_MD:  M_forward = stage_q.md;
            default:   M_forward = 32'd0;
        endcase
    end

    assign dmem.m_data_addr = stage_q.result;
    assign result_M_o       = stage_q.result;
    assign md_M_o           = stage_q.md;
    assign PCn_M_o          = stage_q.pcn;
    assign OP_M_o           = stage_q.op;
    assign A3_M_o           = stage_q.a3;
    assign regWrite_M_o     = stage_q.regwrite;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with a behavioural reference model
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] result_E_o, rt_E_o, PCn_E_o, OP_E_o, md_E_o;
    logic [4:0]  A3_E_o;
    logic        regWrite_E_o;
    logic [3:0]  memOp_E_o;
    logic [1:0]  GRF_WDsel;
    logic [31:0] W_forward;
    logic [4:0]  W_A3;
    logic        W_regWrite;
    logic [31:0] memory_M_o, result_M_o, md_M_o, PCn_M_o, OP_M_o, M_forward;
    logic [4:0]  A3_M_o;
    logic        regWrite_M_o;

    mem_stage_if dmem_if ();

    always #5 clk = ~clk;

    mem_stage dut (
        .clk          (clk),
        .reset        (reset),
        .result_E_o   (result_E_o),
        .rt_E_o       (rt_E_o),
        .PCn_E_o      (PCn_E_o),
        .OP_E_o       (OP_E_o),
        .A3_E_o       (A3_E_o),
        .regWrite_E_o (regWrite_E_o),
        .md_E_o       (md_E_o),
        .memOp_E_o    (memOp_E_o),
        .GRF_WDsel    (GRF_WDsel),
        .W_forward    (W_forward),
        .W_A3         (W_A3),
        .W_regWrite   (W_regWrite),
        .dmem         (dmem_if),
        .memory_M_o   (memory_M_o),
        .result_M_o   (result_M_o),
        .md_M_o       (md_M_o),
        .PCn_M_o      (PCn_M_o),
        .OP_M_o       (OP_M_o),
        .A3_M_o       (A3_M_o),
        .regWrite_M_o (regWrite_M_o),
        .M_forward    (M_forward)
    );

    typedef struct {
        logic [31:0] result, rt, pcn, op, md;
        logic [4:0]  a3;
        logic        rw;
        logic [3:0]  mop;
    } e_t;

    typedef struct {
        logic [31:0] wf, rdata;
        logic [4:0]  wa3;
        logic        wrw;
        logic [1:0]  sel;
    } w_t;

    typedef struct {
        logic [31:0] addr, wdata, mem, result, md, pcn, op, fwd;
        logic [3:0]  be;
        logic [4:0]  a3;
        logic        rw;
    } x_t;

    x_t sb_q[$];
    x_t mon_x;
    int checks = 0;
    int errors = 0;
    e_t cur;
    e_t zero_e;

    function automatic e_t mk_e(logic [3:0] mop, logic [31:0] addr, logic [31:0] rt,
                                logic [31:0] op, logic [4:0] a3, logic rw);
        e_t e;
        e.mop = mop; e.result = addr; e.rt = rt; e.op = op; e.a3 = a3; e.rw = rw;
        e.pcn = $urandom; e.md = $urandom;
        return e;
    endfunction

    function automatic w_t mk_w(logic [31:0] wf, logic [31:0] rdata, logic [4:0] wa3,
                                logic wrw, logic [1:0] sel);
        w_t w;
        w.wf = wf; w.rdata = rdata; w.wa3 = wa3; w.wrw = wrw; w.sel = sel;
        return w;
    endfunction

    // Reference: what the M stage must present while instruction c sits in it
    function automatic x_t model(e_t c, w_t w);
        x_t          x;
        logic [31:0] d;
        logic [1:0]  off;
        logic [15:0] h;
        logic [7:0]  b;
        logic        mis;
        off = c.result[1:0];
        d = (w.wrw && w.wa3 != 5'd0 && w.wa3 == c.op[20:16]) ? w.wf : c.rt;
        h = 16'(w.rdata >> (16 * int'(c.result[1])));
        b = 8'(w.rdata >> (8 * int'(off)));
        x.addr = c.result; x.result = c.result; x.md = c.md; x.pcn = c.pcn;
        x.op = c.op; x.a3 = c.a3; x.rw = c.rw;
        x.be = 4'd0; x.wdata = d; x.mem = 32'd0;
        case (c.mop)
            4'd1: x.mem = w.rdata;
            4'd2: x.mem = 32'($signed(h));
            4'd3: x.mem = 32'(h);
            4'd4: x.mem = 32'($signed(b));
            4'd5: x.mem = 32'(b);
            4'd6: x.be = 4'hF;
            4'd7: begin x.be = c.result[1] ? 4'hC : 4'h3; x.wdata = 32'(d[15:0]) * 32'h0001_0001; end
            4'd8: begin x.be = 4'(1 << off); x.wdata = 32'(d[7:0]) * 32'h0101_0101; end
            default: ;
        endcase
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        if ((c.mop == 4'd1 || c.mop == 4'd6) && off != 2'd0) mis = 1'b1;
        if ((c.mop == 4'd2 || c.mop == 4'd3 || c.mop == 4'd7) && off[0]) mis = 1'b1;
`endif
        if (mis) begin x.be = 4'd0; x.mem = 32'd0; end
        case (w.sel)
            2'b01:   x.fwd = c.result;
            2'b10:   x.fwd = c.pcn + 32'd4;
            2'b11:   x.fwd = c.md;
            default: x.fwd = 32'd0;
        endcase
        return x;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle: E inputs for the next instruction, W/rdata for the one now in M
    task automatic step(input e_t e, input w_t w, input bit rst, input bit chk);
        reset        = rst;
        result_E_o   = e.result;
        rt_E_o       = e.rt;
        PCn_E_o      = e.pcn;
        OP_E_o       = e.op;
        md_E_o       = e.md;
        A3_E_o       = e.a3;
        regWrite_E_o = e.rw;
        memOp_E_o    = e.mop;
        W_forward    = w.wf;
        W_A3         = w.wa3;
        W_regWrite   = w.wrw;
        GRF_WDsel    = w.sel;
        dmem_if.m_data_rdata = w.rdata;
        if (chk) sb_q.push_back(model(cur, w));
        cur = rst ? zero_e : e;
        @(posedge clk);
        #1;
    endtask

    function automatic e_t rand_e();
        e_t e;
        e.mop = 4'($urandom_range(0, 15));
        e.result = $urandom; e.rt = $urandom; e.pcn = $urandom;
        e.op = $urandom; e.md = $urandom;
        e.a3 = 5'($urandom_range(0, 31)); e.rw = 1'($urandom_range(0, 1));
        return e;
    endfunction

    // Monitor: outputs are stable by the falling edge; compare against the oldest expectation
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_x = sb_q.pop_front();
            cmp("m_data_addr", dmem_if.m_data_addr, mon_x.addr);
            cmp("m_data_wdata", dmem_if.m_data_wdata, mon_x.wdata);
            cmp("m_data_byteen", 32'(dmem_if.m_data_byteen), 32'(mon_x.be));
            cmp("memory_M_o", memory_M_o, mon_x.mem);
            cmp("result_M_o", result_M_o, mon_x.result);
            cmp("md_M_o", md_M_o, mon_x.md);
            cmp("PCn_M_o", PCn_M_o, mon_x.pcn);
            cmp("OP_M_o", OP_M_o, mon_x.op);
            cmp("A3_M_o", 32'(A3_M_o), 32'(mon_x.a3));
            cmp("regWrite_M_o", 32'(regWrite_M_o), 32'(mon_x.rw));
            cmp("M_forward", M_forward, mon_x.fwd);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        w_t nofwd;
        w_t w;
        e_t e;
        int guard;
        zero_e = '{default: '0};
        nofwd  = mk_w(32'h0BAD_0BAD, 32'h0, 5'd0, 1'b0, 2'b01);
        cur    = zero_e;

        // Hold reset for two edges so the stage starts from a known zero state
        step(zero_e, nofwd, 1'b1, 1'b0);
        step(zero_e, nofwd, 1'b1, 1'b0);

        // sw 0x12345678 -> 0x100 (also checks the post-reset state)
        step(mk_e(4'd6, 32'h100, 32'h1234_5678, 32'h0, 5'd0, 1'b0), nofwd, 1'b0, 1'b1);
        // sb 0xAB -> 0x103
        step(mk_e(4'd8, 32'h103, 32'h0000_00AB, 32'h0, 5'd0, 1'b0), nofwd, 1'b0, 1'b1);
        // lh / lhu from 0x102
        step(mk_e(4'd2, 32'h102, 32'h0, 32'h0, 5'd3, 1'b1), nofwd, 1'b0, 1'b1);
        step(mk_e(4'd3, 32'h102, 32'h0, 32'h0, 5'd4, 1'b1),
             mk_w(32'h0, 32'h8001_FFFF, 5'd0, 1'b0, 2'b01), 1'b0, 1'b1);
        step(mk_e(4'd6, 32'h104, 32'h1111_1111, 32'h0005_0000, 5'd0, 1'b0),
             mk_w(32'h0, 32'h8001_FFFF, 5'd0, 1'b0, 2'b10), 1'b0, 1'b1);
        // Store with rt field 5: forwarded from W, then W_A3=0 keeps registered rt
        step(mk_e(4'd6, 32'h108, 32'h2222_2222, 32'h0005_0000, 5'd0, 1'b0),
             mk_w(32'hDEAD_BEEF, 32'h0, 5'd5, 1'b1, 2'b11), 1'b0, 1'b1);
        step(mk_e(4'd6, 32'h101, 32'h3333_3333, 32'h0, 5'd0, 1'b0),
             mk_w(32'hDEAD_BEEF, 32'h0, 5'd0, 1'b1, 2'b00), 1'b0, 1'b1);
        // Misaligned sw to 0x101, then lw r7 followed directly by sb of r7
        step(mk_e(4'd1, 32'h200, 32'h0, 32'h0, 5'd7, 1'b1), nofwd, 1'b0, 1'b1);
        step(mk_e(4'd8, 32'h003, 32'h0000_0055, 32'h0007_0000, 5'd0, 1'b0),
             mk_w(32'h0, 32'hCAFE_F00D, 5'd0, 1'b0, 2'b00), 1'b0, 1'b1);
        step(rand_e(), mk_w(32'hCAFE_F00D, 32'h0, 5'd7, 1'b1, 2'b01), 1'b1, 1'b1);
        // Reset landed on the pending sb: the stage must now be empty
        step(rand_e(), nofwd, 1'b0, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            e = rand_e();
            w = mk_w($urandom, $urandom, 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) w.wa3 = cur.op[20:16];
            step(e, w, ($urandom_range(0, 63) == 0), 1'b1);
        end

        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
